count_monitor: RTL and testbench

Downstream observer for the 4-bit mod-12 up/down counter. It samples the counter's `count` output, classifies each transition, tracks direction and wrap-arounds, and flags illegal values. Notable events go into a small FIFO that a scoreboard or status block drains over a valid/ready interface.

---
 rtl/count_monitor_if.sv | 11 +
 rtl/count_monitor.sv | 198 +++++++++++++++++++
 tb/tb_count_monitor.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/count_monitor_if.sv
// Event stream from count_monitor to a scoreboard or status block.
// master drives valid/code/value, slave returns ready.
interface count_monitor_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_code;
    logic [3:0] evt_value;

    modport master (output evt_valid, output evt_code, output evt_value, input evt_ready);
    modport slave  (input evt_valid, input evt_code, input evt_value, output evt_ready);
endinterface

// File: rtl/count_monitor.sv
// Observer for the mod-(MAX_VAL+1) up/down counter: classifies transitions, queues events in a FIFO.
// Latency: event sampled at edge N is visible at the FIFO head after edge N (no empty bypass).
// Backpressure: evt_ready holds the head; a full FIFO drops new events and sets ovf. COUNT_MONITOR_STEP_EVT_EN adds UP/DOWN events.

module count_monitor_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   used;
    logic          push_fire;
    logic          pop_fire;

    assign pop_vld   = (used != '0);
    assign pop_fire  = pop_vld && pop_rdy;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push_rdy  = (used != FULL_CNT) || pop_fire;
    assign push_fire = push_vld && push_rdy;
    assign pop_dat   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_fire) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_fire) rd_ptr <= rd_ptr + AW'(1);
            case ({push_fire, pop_fire})
                2'b10:   used <= used + (AW+1)'(1);
                2'b01:   used <= used - (AW+1)'(1);
                default: used <= used;
            endcase
        end
    end
endmodule

module count_monitor #(
    parameter int MAX_VAL    = 11,
    parameter int WRAP_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          count,
    input  logic                en,
    input  logic                clr,
    count_monitor_if.master     evt,
    output logic                dir,
    output logic [WRAP_W-1:0]   wrap_cnt,
    output logic                illegal,
    output logic                ovf
);
    typedef enum logic {INIT, TRACK} state_t;

    typedef struct packed {
        logic [2:0] code;
        logic [3:0] value;
    } evt_t;

    localparam logic [3:0] MAX_V      = 4'(MAX_VAL);
    localparam logic [2:0] C_WRAP_UP  = 3'd1;
    localparam logic [2:0] C_WRAP_DN  = 3'd2;
    localparam logic [2:0] C_JUMP     = 3'd3;
    localparam logic [2:0] C_ILLEGAL  = 3'd4;
    localparam logic [2:0] C_STEP_UP  = 3'd5;
    localparam logic [2:0] C_STEP_DN  = 3'd6;

    state_t     state;
    logic [3:0] prev;
    logic       evt_push;
    logic [2:0] evt_c;
    logic       dir_nxt;
    logic       wrap_hit;
    logic       ill_hit;
    logic       push_rdy;
    logic       drop;
    evt_t       push_dat;
    evt_t       head;

    always_comb begin
        evt_push = 1'b0;
        evt_c    = 3'd0;
        dir_nxt  = dir;
        wrap_hit = 1'b0;
        ill_hit  = 1'b0;
        if (en) begin
            if (count > MAX_V) begin
                evt_push = 1'b1;
                evt_c    = C_ILLEGAL;
                ill_hit  = 1'b1;
            end else if (state == TRACK) begin
                // prev is known legal past the first branch, so +/-1 cannot alias 15/0.
                if (prev > MAX_V) begin
                    evt_push = 1'b1;
                    evt_c    = C_JUMP;
                end else if (prev == count) begin
                    evt_push = 1'b0;
                end else if (prev == MAX_V && count == 4'd0) begin
                    evt_push = 1'b1;
                    evt_c    = C_WRAP_UP;
                    dir_nxt  = 1'b1;
                    wrap_hit = 1'b1;
                end else if (prev == 4'd0 && count == MAX_V) begin
                    evt_push = 1'b1;
                    evt_c    = C_WRAP_DN;
                    dir_nxt  = 1'b0;
                    wrap_hit = 1'b1;
                end else if (count == prev + 4'd1) begin
                    dir_nxt = 1'b1;
`ifdef COUNT_MONITOR_STEP_EVT_EN
                    evt_push = 1'b1;
                    evt_c    = C_STEP_UP;
`else
                    evt_c    = 3'd0;
`endif
                end else if (count == prev - 4'd1) begin
                    dir_nxt = 1'b0;
`ifdef COUNT_MONITOR_STEP_EVT_EN
                    evt_push = 1'b1;
                    evt_c    = C_STEP_DN;
`else
                    evt_c    = 3'd0;
`endif
                end else begin
                    evt_push = 1'b1;
                    evt_c    = C_JUMP;
                end
            end
        end
    end

    assign push_dat = '{code: evt_c, value: count};
    assign drop     = evt_push && !push_rdy;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= INIT;
            prev     <= '0;
            dir      <= 1'b1;
            wrap_cnt <= '0;
            illegal  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (en) begin
                state <= TRACK;
                prev  <= count;
                dir   <= dir_nxt;
            end
            // Sticky sets take priority over a coincident clr.
            if (ill_hit)  illegal <= 1'b1;
            else if (clr) illegal <= 1'b0;
            if (drop)     ovf <= 1'b1;
            else if (clr) ovf <= 1'b0;
            if (wrap_hit) begin
                if (clr)                wrap_cnt <= WRAP_W'(1);
                else if (~&wrap_cnt)    wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end else if (clr) begin
                wrap_cnt <= '0;
            end
        end
    end

    count_monitor_fifo #(
        .W     ($bits(evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (evt_push),
        .push_dat (push_dat),
        .push_rdy (push_rdy),
        .pop_vld  (evt.evt_valid),
        .pop_rdy  (evt.evt_ready),
        .pop_dat  (head)
    );

    assign evt.evt_code  = head.code;
    assign evt.evt_value = head.value;
endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor; expected events are hand-computed per scenario.
module tb_count_monitor;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] count = 4'd0;
    logic       en    = 1'b0;
    logic       clr   = 1'b0;
    logic       dir;
    logic [7:0] wrap_cnt;
    logic       illegal;
    logic       ovf;
    int         vectors    = 0;
    int         miscompares = 0;
    logic [6:0] got[$];

    count_monitor_if ev();

    count_monitor dut (
        .clock    (clock),
        .reset    (reset),
        .count    (count),
        .en       (en),
        .clr      (clr),
        .evt      (ev),
        .dir      (dir),
        .wrap_cnt (wrap_cnt),
        .illegal  (illegal),
        .ovf      (ovf)
    );

    always #5 clock = ~clock;

    // Inputs change 1ns after posedge, so the negedge view matches the next posedge.
    always @(negedge clock)
        if (!reset && ev.evt_valid && ev.evt_ready) got.push_back({ev.evt_code, ev.evt_value});

    task automatic sample(input logic [3:0] v, input logic c = 1'b0);
        count = v; en = 1'b1; clr = c;
        @(posedge clock); #1;
        en = 1'b0; clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic test_reset;
        reset = 1'b1; ev.evt_ready = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(1);
        vectors++; if (ev.evt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", ev.evt_valid); end
        vectors++; if (ev.evt_code !== 3'd0) begin miscompares++; $display("FAIL reset_code got %0d exp 0", ev.evt_code); end
        vectors++; if (ev.evt_value !== 4'd0) begin miscompares++; $display("FAIL reset_value got %0d exp 0", ev.evt_value); end
        vectors++; if (dir !== 1'b1) begin miscompares++; $display("FAIL reset_dir got %b exp 1", dir); end
        vectors++; if (wrap_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_wrap got %0d exp 0", wrap_cnt); end
        vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got %b exp 0", illegal); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_wrap_up;
        logic [6:0] exp[$];
        exp = '{{3'd1, 4'd0}};
        got.delete();
        ev.evt_ready = 1'b1;
        sample(4'd9); sample(4'd10); sample(4'd11); sample(4'd0);
        vectors++; if (ev.evt_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_up_latency valid got %b exp 1", ev.evt_valid); end
        sample(4'd1);
        idle(3);
        vectors++; if (got.size() != exp.size()) begin miscompares++; $display("FAIL wrap_up_count got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL wrap_up_evt%0d got %h exp %h", i, got[i], exp[i]); end
        end
        vectors++; if (wrap_cnt !== 8'd1) begin miscompares++; $display("FAIL wrap_up_cnt got %0d exp 1", wrap_cnt); end
        vectors++; if (dir !== 1'b1) begin miscompares++; $display("FAIL wrap_up_dir got %b exp 1", dir); end
    endtask

    task automatic test_wrap_dn;
        logic [6:0] exp[$];
        exp = '{{3'd2, 4'd11}};
        got.delete();
        sample(4'd1); sample(4'd0);
        vectors++; if (dir !== 1'b0) begin miscompares++; $display("FAIL down_step_dir got %b exp 0", dir); end
        sample(4'd11); sample(4'd10);
        idle(3);
        vectors++; if (got.size() != exp.size()) begin miscompares++; $display("FAIL wrap_dn_count got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL wrap_dn_evt%0d got %h exp %h", i, got[i], exp[i]); end
        end
        vectors++; if (wrap_cnt !== 8'd2) begin miscompares++; $display("FAIL wrap_dn_cnt got %0d exp 2", wrap_cnt); end
        vectors++; if (dir !== 1'b0) begin miscompares++; $display("FAIL wrap_dn_dir got %b exp 0", dir); end
    endtask

    task automatic test_jump_illegal;
        logic [6:0] exp[$];
        // 10->3 and 3->8 are loads; 14 while illegal still reports; 14->2 is a jump out of illegal.
        exp = '{{3'd3, 4'd3}, {3'd3, 4'd8}, {3'd4, 4'd13}, {3'd4, 4'd14}, {3'd3, 4'd2}};
        got.delete();
        sample(4'd3); sample(4'd8); sample(4'd13);
        vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_set got %b exp 1", illegal); end
        sample(4'd14, 1'b1);
        vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_set_beats_clr got %b exp 1", illegal); end
        sample(4'd2);
        idle(3);
        vectors++; if (got.size() != exp.size()) begin miscompares++; $display("FAIL jump_count got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL jump_evt%0d got %h exp %h", i, got[i], exp[i]); end
        end
        clr = 1'b1; idle(1); clr = 1'b0;
        vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL illegal_clr got %b exp 0", illegal); end
        vectors++; if (wrap_cnt !== 8'd0) begin miscompares++; $display("FAIL wrap_clr got %0d exp 0", wrap_cnt); end
    endtask

    task automatic test_overflow;
        logic [6:0] exp[$];
        exp = '{{3'd3, 4'd0}, {3'd3, 4'd5}, {3'd3, 4'd0}, {3'd3, 4'd5}, {3'd3, 4'd0}};
        got.delete();
        ev.evt_ready = 1'b0;
        sample(4'd0); sample(4'd5); sample(4'd0); sample(4'd5);
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_at_full got %b exp 0", ovf); end
        sample(4'd0);
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_drop got %b exp 1", ovf); end
        sample(4'd5);
        vectors++; if ({ev.evt_code, ev.evt_value} !== {3'd3, 4'd0}) begin miscompares++; $display("FAIL head_hold got %h exp %h", {ev.evt_code, ev.evt_value}, {3'd3, 4'd0}); end
        clr = 1'b1; idle(1); clr = 1'b0;
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got %b exp 0", ovf); end
        vectors++; if (ev.evt_valid !== 1'b1) begin miscompares++; $display("FAIL clr_keeps_fifo got %b exp 1", ev.evt_valid); end
        // Full FIFO with a pop in the same cycle must take the new event.
        ev.evt_ready = 1'b1;
        sample(4'd0);
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL full_pop_push ovf got %b exp 0", ovf); end
        idle(4);
        vectors++; if (got.size() != exp.size()) begin miscompares++; $display("FAIL drain_count got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL drain_evt%0d got %h exp %h", i, got[i], exp[i]); end
        end
        vectors++; if (ev.evt_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got %b exp 0", ev.evt_valid); end
    endtask

    task automatic test_saturate;
        got.delete();
        ev.evt_ready = 1'b1;
        for (int w = 1; w <= 300; w++) begin
            for (int v = 1; v <= 11; v++) sample(4'(v));
            sample(4'd0);
            if (w == 254) begin
                vectors++; if (wrap_cnt !== 8'd254) begin miscompares++; $display("FAIL wrap_254 got %0d exp 254", wrap_cnt); end
            end
            if (w == 255) begin
                vectors++; if (wrap_cnt !== 8'd255) begin miscompares++; $display("FAIL wrap_255 got %0d exp 255", wrap_cnt); end
            end
        end
        vectors++; if (wrap_cnt !== 8'd255) begin miscompares++; $display("FAIL wrap_sat got %0d exp 255", wrap_cnt); end
        for (int v = 1; v <= 11; v++) sample(4'(v));
        sample(4'd0, 1'b1);
        vectors++; if (wrap_cnt !== 8'd1) begin miscompares++; $display("FAIL wrap_with_clr got %0d exp 1", wrap_cnt); end
        idle(3);
        vectors++; if (got.size() != 301) begin miscompares++; $display("FAIL wrap_evt_count got %0d exp 301", got.size()); end
    endtask

    task automatic test_reset_mid;
        got.delete();
        sample(4'd11);
        ev.evt_ready = 1'b0;
        sample(4'd13); sample(4'd0);
        vectors++; if (ev.evt_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_valid got %b exp 1", ev.evt_valid); end
        reset = 1'b1; idle(1); reset = 1'b0;
        vectors++; if (ev.evt_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid got %b exp 0", ev.evt_valid); end
        vectors++; if ({ev.evt_code, ev.evt_value} !== 7'd0) begin miscompares++; $display("FAIL mid_reset_head got %h exp 00", {ev.evt_code, ev.evt_value}); end
        vectors++; if (dir !== 1'b1) begin miscompares++; $display("FAIL mid_reset_dir got %b exp 1", dir); end
        vectors++; if (wrap_cnt !== 8'd0) begin miscompares++; $display("FAIL mid_reset_wrap got %0d exp 0", wrap_cnt); end
        vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL mid_reset_illegal got %b exp 0", illegal); end
        ev.evt_ready = 1'b1;
        sample(4'd7);
        idle(3);
        vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL init_no_event got %0d exp 0", got.size()); end
    endtask

    task automatic test_step;
        logic [6:0] exp[$];
`ifdef COUNT_MONITOR_STEP_EVT_EN
        exp = '{{3'd3, 4'd4}, {3'd5, 4'd5}, {3'd6, 4'd4}};
`else
        exp = '{{3'd3, 4'd4}};
`endif
        got.delete();
        sample(4'd4); sample(4'd5);
        vectors++; if (dir !== 1'b1) begin miscompares++; $display("FAIL step_up_dir got %b exp 1", dir); end
        sample(4'd4);
        vectors++; if (dir !== 1'b0) begin miscompares++; $display("FAIL step_dn_dir got %b exp 0", dir); end
        idle(4);
        vectors++; if (got.size() != exp.size()) begin miscompares++; $display("FAIL step_count got %0d exp %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL step_evt%0d got %h exp %h", i, got[i], exp[i]); end
        end
    endtask

    initial begin
        ev.evt_ready = 1'b0;
        test_reset;
        test_wrap_up;
        test_wrap_dn;
        test_jump_illegal;
        test_overflow;
        test_saturate;
        test_reset_mid;
        test_step;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
